hyperram_arbiter: RTL
=====================

// Module: hyperram_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares one hyperram controller core among
//  NUM_REQ requesters (e.g. instruction fetch, data port, DMA).
//  Latches the winner's request, drives the core's valid/wren/addr/data/sel/
//  regspace inputs and holds them until the core completes, then returns the
//  response to the winner.
//  Includes a watchdog that turns a stuck core transaction into an error response.
// PARAMETERS
//  NUM_REQ      2    number of requesters, 2..8
//  TIMEOUT_CYC  255  max cycles in ISSUE before error; 0 disables the watchdog
//  CNT_W        8    width of the watchdog counter; TIMEOUT_CYC < 2**CNT_W
// PORTS
//  clk_i           in   1           system clock
//  rst_i           in   1           asynchronous reset, active high
//  req_valid_i     in   NUM_REQ     request strobe per requester
//  req_wren_i      in   NUM_REQ     1=write, 0=read
//  req_addr_i      in   32*NUM_REQ  byte address; requester k at [32k+:32]
//  req_data_i      in   32*NUM_REQ  write data; requester k at [32k+:32]
//  req_sel_i       in   4*NUM_REQ   byte enables; requester k at [4k+:4]
//  req_regspace_i  in   NUM_REQ     1=register space access
//  req_ready_o     out  NUM_REQ     one-cycle completion pulse to the winner
//  req_err_o       out  NUM_REQ     one-cycle timeout-error pulse to the winner
//  req_data_o      out  32          read data, valid with req_ready_o
//  grant_o         out  NUM_REQ     one-hot current owner; 0 when IDLE
//  hr_valid_o      out  1           to core valid_i
//  hr_wren_o       out  1           to core wren_i
//  hr_addr_o       out  32          to core addr_i
//  hr_data_o       out  32          to core data_i
//  hr_sel_o        out  4           to core sel_i
//  hr_regspace_o   out  1           to core regspace_i
//  hr_ready_i      in   1           core completion pulse; read data valid
//  hr_data_i       in   32          core read data
// BEHAVIOUR
//  Reset (async, rst_i=1):
//   - all outputs 0; state IDLE; watchdog counter 0.
//   - rr_ptr = NUM_REQ-1, so requester 0 wins first.
//   - Mid-transaction reset drops hr_valid_o immediately; no response is issued.
//  FSM states IDLE, ISSUE, RESP, DRAIN:
//   - IDLE: if any req_valid_i, pick the first set bit searching from
//     rr_ptr+1 upward (modulo NUM_REQ). Register the winner's payload into
//     hr_* and its one-hot into grant_o; set rr_ptr=winner; go to ISSUE.
//     hr_valid_o rises on the cycle after req_valid_i is first sampled high.
//   - ISSUE: hr_valid_o=1 and hr_* held stable.
//     On hr_ready_i: capture hr_data_i into req_data_o; go to RESP.
//     Otherwise the counter increments; when it reaches TIMEOUT_CYC (nonzero),
//     go to DRAIN and pulse req_err_o[winner].
//     If hr_ready_i and the timeout fall in the same cycle, hr_ready_i wins.
//   - RESP: req_ready_o[winner]=1 for exactly this cycle; hr_valid_o=0;
//     grant_o cleared; go to IDLE. Minimum latency from request to
//     req_ready_o is 3 cycles when hr_ready_i arrives on the first ISSUE cycle.
//   - DRAIN: hr_valid_o=0; no grants; wait for a late hr_ready_i (data
//     discarded), then go to IDLE.
//  Requester rules:
//   - Payload and req_valid_i are held until req_ready_o or req_err_o.
//   - The arbiter samples the payload only in IDLE.
//   - A requester may deassert req_valid_i early; if it has already been
//     granted, the transaction still completes and the response is still issued.
//  Fairness and outputs:
//   - With all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
//   - At most one bit of req_ready_o|req_err_o is set per cycle.
//   - req_data_o holds its value until the next capture; it is 0 after reset.
//   - The watchdog counter is CNT_W bits, saturating, and clears on entry to ISSUE.
// TESTING
//  - Reset, then req0 reads 0x0000_0100; core returns ready on the 1st ISSUE
//    cycle with data 0xDEAD_BEEF
//    -> hr_valid_o high 1 cycle, addr 0x100, wren 0;
//       req_ready_o=01 on cycle 3 with req_data_o=0xDEAD_BEEF.
//  - Both requesters continuously valid, core ready after 4 cycles, 6 transfers
//    -> grant order 0,1,0,1,0,1; hr_* always match the granted requester.
//  - req1 writes 0x1234_5678, sel=0011, regspace=1 while req0 idle
//    -> hr_wren_o=1, hr_sel_o=0011, hr_regspace_o=1; stable until hr_ready_i.
//  - TIMEOUT_CYC=10, core never ready
//    -> req_err_o pulses after 10 ISSUE cycles; DRAIN entered; a new request is
//       not granted until hr_ready_i, after which the request is granted.
//  - Timeout and hr_ready_i coincide on cycle 10
//    -> req_ready_o pulses; req_err_o stays 0.
//  - Assert rst_i during ISSUE
//    -> hr_valid_o and grant_o go 0 in the same cycle; after release
//       requester 0 has priority.

Source files
------------

// File: rtl/hyperram_arbiter.sv
// Round-robin arbiter that shares one hyperram controller core among NUM_REQ requesters.
// Holds the winner's request on the core port until completion or watchdog timeout.
module hyperram_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ-1:0]     req_wren_i,
    input  logic [32*NUM_REQ-1:0]  req_addr_i,
    input  logic [32*NUM_REQ-1:0]  req_data_i,
    input  logic [4*NUM_REQ-1:0]   req_sel_i,
    input  logic [NUM_REQ-1:0]     req_regspace_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     req_err_o,
    output logic [31:0]            req_data_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   hr_valid_o,
    output logic                   hr_wren_o,
    output logic [31:0]            hr_addr_o,
    output logic [31:0]            hr_data_o,
    output logic [3:0]             hr_sel_o,
    output logic                   hr_regspace_o,
    input  logic                   hr_ready_i,
    input  logic [31:0]            hr_data_i,
    output logic [1:0]             state_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               win_found;
    logic [NUM_REQ-1:0] owner_q;
    logic [CNT_W-1:0]   wd_cnt_q;
    logic [CNT_W:0]     cnt_inc;
    logic               timeout_hit;
    logic               err_q;

    logic [31:0] addr_arr [NUM_REQ];
    logic [31:0] data_arr [NUM_REQ];
    logic [3:0]  sel_arr  [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            addr_arr[k] = req_addr_i[32*k +: 32];
            data_arr[k] = req_data_i[32*k +: 32];
            sel_arr[k]  = req_sel_i[4*k +: 4];
        end
    end

    // Search starts just after the last winner, so the last winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_idx = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_found && req_valid_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign cnt_inc     = {1'b0, wd_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == (CNT_W+1)'(TIMEOUT_CYC));

    // A completion in the same cycle as the timeout takes precedence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = ISSUE;
            ISSUE: begin
                if (hr_ready_i)       state_d = RESP;
                else if (timeout_hit) state_d = DRAIN;
            end
            RESP:    state_d = IDLE;
            DRAIN:   if (hr_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
            owner_q       <= '0;
            wd_cnt_q      <= '0;
            err_q         <= 1'b0;
            req_data_o    <= '0;
            hr_wren_o     <= 1'b0;
            hr_addr_o     <= '0;
            hr_data_o     <= '0;
            hr_sel_o      <= '0;
            hr_regspace_o <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == ISSUE) && (state_d == DRAIN);
            if (state_q == IDLE && win_found) begin
                owner_q       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                rr_ptr_q      <= win_idx;
                wd_cnt_q      <= '0;
                hr_wren_o     <= req_wren_i[win_idx];
                hr_addr_o     <= addr_arr[win_idx];
                hr_data_o     <= data_arr[win_idx];
                hr_sel_o      <= sel_arr[win_idx];
                hr_regspace_o <= req_regspace_i[win_idx];
            end
            if (state_q == ISSUE) begin
                if (hr_ready_i)
                    req_data_o <= hr_data_i;
                else if (!cnt_inc[CNT_W])
                    wd_cnt_q <= cnt_inc[CNT_W-1:0];
            end
        end
    end

    // owner_q stays valid through RESP/DRAIN so the response can be routed.
    assign hr_valid_o  = (state_q == ISSUE);
    assign grant_o     = hr_valid_o ? owner_q : '0;
    assign req_ready_o = (state_q == RESP) ? owner_q : '0;
    assign req_err_o   = err_q ? owner_q : '0;
    assign state_o     = state_q;

endmodule
